// File: rtl/sram_bist_ctrl.sv
// March-test BIST initiator for a single SRAM: M0..M3 march elements over the full address
// space, with error counting and first-failure capture.
module sram_bist_ctrl #(
  parameter int                 DATA_W  = 4,
  parameter int                 ADDR_W  = 3,
  parameter logic [DATA_W-1:0]  PATTERN = 4'b0101
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] memDataOut,
  output logic [DATA_W-1:0] memDataIn,
  output logic [ADDR_W-1:0] memAddress,
  output logic              memCS,
  output logic              memWE,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        errCount,
  output logic [ADDR_W-1:0] failAddr,
  output logic [1:0]        failPhase,
  output logic [DATA_W-1:0] failData
);

  // state  | meaning
  // IDLE   | waiting for start after reset
  // M0..M3 | march element in progress (ops sequenced by op/addr)
  // DONE   | results valid, waiting for a restart
  typedef enum logic [2:0] {S_IDLE, S_M0, S_M1, S_M2, S_M3, S_DONE} state_t;
  typedef enum logic [1:0] {OP_RD, OP_CMP, OP_WR} op_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state, state_nxt;
  op_t               op, op_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic              clear;

  logic              active_nxt;
  logic              we_nxt;
  logic [DATA_W-1:0] wdata_nxt;

  logic              cmp_en;
  logic [DATA_W-1:0] cmp_exp;
  logic [1:0]        cmp_phase;
  logic              mismatch;

  logic [7:0]        err_count_nxt;
  logic [ADDR_W-1:0] fail_addr_nxt;
  logic [1:0]        fail_phase_nxt;
  logic [DATA_W-1:0] fail_data_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op    <= OP_RD;
      addr  <= '0;
    end else begin
      state <= state_nxt;
      op    <= op_nxt;
      addr  <= addr_nxt;
    end
  end

  // state/op/addr always describe the op currently driven on the SRAM port
  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    addr_nxt  = addr;
    clear     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_M0;
          op_nxt    = OP_WR;
          addr_nxt  = '0;
          clear     = 1'b1;
        end
      end
      S_M0: begin
        op_nxt = OP_WR;
        if (addr == ADDR_MAX) begin
          state_nxt = S_M1;
          op_nxt    = OP_RD;
          addr_nxt  = '0;
        end else begin
          addr_nxt = addr + ADDR_ONE;
        end
      end
      S_M1: begin
        case (op)
          OP_RD:   op_nxt = OP_CMP;
          OP_CMP:  op_nxt = OP_WR;
          default: begin
            op_nxt = OP_RD;
            if (addr == ADDR_MAX) begin
              state_nxt = S_M2;
              addr_nxt  = ADDR_MAX;
            end else begin
              addr_nxt = addr + ADDR_ONE;
            end
          end
        endcase
      end
      S_M2: begin
        case (op)
          OP_RD:   op_nxt = OP_CMP;
          OP_CMP:  op_nxt = OP_WR;
          default: begin
            op_nxt = OP_RD;
            if (addr == '0) begin
              state_nxt = S_M3;
              addr_nxt  = ADDR_MAX;
            end else begin
              addr_nxt = addr - ADDR_ONE;
            end
          end
        endcase
      end
      S_M3: begin
        case (op)
          OP_RD:   op_nxt = OP_CMP;
          default: begin
            op_nxt = OP_RD;
            if (addr == '0) begin
              state_nxt = S_DONE;
              addr_nxt  = '0;
            end else begin
              addr_nxt = addr - ADDR_ONE;
            end
          end
        endcase
      end
      default: begin
        state_nxt = S_IDLE;
        op_nxt    = OP_RD;
        addr_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    active_nxt = (state_nxt == S_M0) || (state_nxt == S_M1) ||
                 (state_nxt == S_M2) || (state_nxt == S_M3);
    we_nxt     = active_nxt && (op_nxt == OP_WR);
    wdata_nxt  = (state_nxt == S_M1) ? ~PATTERN : PATTERN;
  end

  // memDataOut is sampled at the close of every CMP cycle
  always_comb begin
    cmp_en    = 1'b0;
    cmp_exp   = PATTERN;
    cmp_phase = 2'd0;
    case (state)
      S_M1: begin cmp_en = (op == OP_CMP); cmp_exp = PATTERN;  cmp_phase = 2'd1; end
      S_M2: begin cmp_en = (op == OP_CMP); cmp_exp = ~PATTERN; cmp_phase = 2'd2; end
      S_M3: begin cmp_en = (op == OP_CMP); cmp_exp = PATTERN;  cmp_phase = 2'd3; end
      default: ;
    endcase
    mismatch = cmp_en && (memDataOut != cmp_exp);
  end

  always_comb begin
    err_count_nxt  = errCount;
    fail_addr_nxt  = failAddr;
    fail_phase_nxt = failPhase;
    fail_data_nxt  = failData;
    if (clear) begin
      err_count_nxt  = '0;
      fail_addr_nxt  = '0;
      fail_phase_nxt = '0;
      fail_data_nxt  = '0;
    end else if (mismatch) begin
      if (errCount != 8'hFF) err_count_nxt = errCount + 8'd1;
      // a zero count means nothing has been captured yet in this run
      if (errCount == 8'd0) begin
        fail_addr_nxt  = addr;
        fail_phase_nxt = cmp_phase;
        fail_data_nxt  = memDataOut;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memCS      <= 1'b0;
      memWE      <= 1'b0;
      memAddress <= '0;
      memDataIn  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      errCount   <= '0;
      failAddr   <= '0;
      failPhase  <= '0;
      failData   <= '0;
    end else begin
      memCS      <= active_nxt;
      memWE      <= we_nxt;
      memAddress <= active_nxt ? addr_nxt : '0;
      memDataIn  <= we_nxt ? wdata_nxt : '0;
      busy       <= active_nxt;
      done       <= (state_nxt == S_DONE);
      pass       <= (state_nxt == S_DONE) && (err_count_nxt == 8'd0);
      errCount   <= err_count_nxt;
      failAddr   <= fail_addr_nxt;
      failPhase  <= fail_phase_nxt;
      failData   <= fail_data_nxt;
    end
  end

endmodule
